// File: rtl/enc4to2_seq.sv
// Sequential 4-to-2 encoder: latches request lines into a pending register and
// hands out one encoded index at a time over a valid/ack handshake.
module enc4to2_seq #(
  parameter bit RR = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic [3:0] req_i,
  output logic [1:0] out_o,
  output logic       out_valid_o,
  input  logic       out_ack_i,
  output logic [3:0] pending_o,
  output logic       dup_err_o
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] pend_q, pend_d;
  logic [1:0] out_q, out_d;
  logic       valid_q, valid_d;
  logic       dup_q, dup_d;
  logic [1:0] last_q, last_d;

  logic [3:0] cand_s;
  logic [1:0] sel_s;
  logic [3:0] clr_s;
  logic       load_s;

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  function automatic logic [1:0] sel_fixed(input logic [3:0] v);
    logic [1:0] r;
    if (v[3]) begin
      r = 2'd3;
    end else if (v[2]) begin
      r = 2'd2;
    end else if (v[1]) begin
      r = 2'd1;
    end else begin
      r = 2'd0;
    end
    return r;
  endfunction

  // Scan starts one past the last grant and wraps; i=4 wraps back onto last itself.
  function automatic logic [1:0] sel_rr(input logic [3:0] v, input logic [1:0] last);
    logic [1:0] r;
    logic [1:0] idx;
    logic       found;
    r     = 2'd0;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = last + i[1:0];
      if (!found && v[idx]) begin
        r     = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return r;
  endfunction

  // Next-state, grant selection and pending-register update.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    valid_d = valid_q;
    last_d  = last_q;
    load_s  = 1'b0;

    // The grant on display is never a candidate for the back-to-back reload.
    if (state_q == HOLD) begin
      cand_s = pend_q & ~onehot(out_q);
    end else begin
      cand_s = pend_q;
    end

    if (RR) begin
      sel_s = sel_rr(cand_s, last_q);
    end else begin
      sel_s = sel_fixed(cand_s);
    end

    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (cand_s != 4'd0) begin
          load_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (out_ack_i) begin
          if (cand_s != 4'd0) begin
            load_s = 1'b1;
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase

    if (load_s) begin
      out_d   = sel_s;
      valid_d = 1'b1;
      last_d  = sel_s;
      state_d = HOLD;
      clr_s   = onehot(sel_s);
    end else begin
      clr_s   = 4'd0;
    end

    if (enable_i) begin
      pend_d = (pend_q & ~clr_s) | req_i;
      dup_d  = |(req_i & pend_q & ~clr_s);
    end else begin
      pend_d = pend_q & ~clr_s;
      dup_d  = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pend_q  <= 4'd0;
      out_q   <= 2'd0;
      valid_q <= 1'b0;
      dup_q   <= 1'b0;
      last_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      dup_q   <= dup_d;
      last_q  <= last_d;
    end
  end

  assign out_o       = out_q;
  assign out_valid_o = valid_q;
  assign pending_o   = pend_q;
  assign dup_err_o   = dup_q;

endmodule

// File: tb/tb_enc4to2_seq.sv
// Directed bench for enc4to2_seq: a fixed-priority and a round-robin instance share stimulus.
module tb_enc4to2_seq;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [3:0] req;
  logic       ack;

  logic [1:0] out0, out1;
  logic       val0, val1;
  logic [3:0] pend0, pend1;
  logic       dup0, dup1;

  int n_cmp;
  int n_err;

  enc4to2_seq #(.RR(1'b0)) dut0 (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .req_i(req),
    .out_o(out0), .out_valid_o(val0), .out_ack_i(ack),
    .pending_o(pend0), .dup_err_o(dup0)
  );

  enc4to2_seq #(.RR(1'b1)) dut1 (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .req_i(req),
    .out_o(out1), .out_valid_o(val1), .out_ack_i(ack),
    .pending_o(pend1), .dup_err_o(dup1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; enable = 1'b0; req = 4'd0; ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (val0 !== 1'b0 || pend0 !== 4'd0 || out0 !== 2'd0 || dup0 !== 1'b0) begin
      n_err++; $display("FAIL reset_init: got v=%b p=%b o=%b d=%b want 0/0000/00/0", val0, pend0, out0, dup0);
    end
    @(negedge clk); rst = 1'b0;
    enable = 1'b1; req = 4'b1111;
    step();
    req = 4'd0;
    step();
    n_cmp++; if (val0 !== 1'b1 || out0 !== 2'd3 || pend0 !== 4'b0111) begin
      n_err++; $display("FAIL reset_prehold: got v=%b o=%b p=%b want 1/11/0111", val0, out0, pend0);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (val0 !== 1'b0 || pend0 !== 4'd0 || out0 !== 2'd0) begin
      n_err++; $display("FAIL reset_async0: got v=%b p=%b o=%b want 0/0000/00", val0, pend0, out0);
    end
    n_cmp++; if (val1 !== 1'b0 || pend1 !== 4'd0 || out1 !== 2'd0) begin
      n_err++; $display("FAIL reset_async1: got v=%b p=%b o=%b want 0/0000/00", val1, pend1, out1);
    end
    do_reset();
  endtask

  task automatic test_single();
    enable = 1'b1; req = 4'b0100; ack = 1'b0;
    step();
    req = 4'd0;
    n_cmp++; if (val0 !== 1'b0 || pend0 !== 4'b0100) begin
      n_err++; $display("FAIL single_latency: got v=%b p=%b want 0/0100", val0, pend0);
    end
    step();
    n_cmp++; if (val0 !== 1'b1 || out0 !== 2'd2) begin
      n_err++; $display("FAIL single_grant: got v=%b o=%b want 1/10", val0, out0);
    end
    step(); step();
    n_cmp++; if (val0 !== 1'b1 || out0 !== 2'd2) begin
      n_err++; $display("FAIL single_hold: got v=%b o=%b want 1/10", val0, out0);
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    n_cmp++; if (val0 !== 1'b0 || out0 !== 2'd2) begin
      n_err++; $display("FAIL single_release: got v=%b o=%b want 0/10", val0, out0);
    end
  endtask

  task automatic test_multi();
    logic [1:0] exp_seq [4];
    exp_seq[0] = 2'd3; exp_seq[1] = 2'd2; exp_seq[2] = 2'd1; exp_seq[3] = 2'd0;
    do_reset();
    enable = 1'b1; req = 4'b1111;
    step();
    req = 4'd0; ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if (val0 !== 1'b1 || out0 !== exp_seq[i]) begin
        n_err++; $display("FAIL multi_grant%0d: got v=%b o=%b want 1/%b", i, val0, out0, exp_seq[i]);
      end
    end
    step();
    n_cmp++; if (val0 !== 1'b0 || pend0 !== 4'd0) begin
      n_err++; $display("FAIL multi_drain: got v=%b p=%b want 0/0000", val0, pend0);
    end
    ack = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_seq [4];
    exp_seq[0] = 2'd0; exp_seq[1] = 2'd1; exp_seq[2] = 2'd2; exp_seq[3] = 2'd3;
    do_reset();
    enable = 1'b1; req = 4'b1111;
    step();
    req = 4'd0; ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if (val1 !== 1'b1 || out1 !== exp_seq[i]) begin
        n_err++; $display("FAIL rr_grant%0d: got v=%b o=%b want 1/%b", i, val1, out1, exp_seq[i]);
      end
    end
    step();
    n_cmp++; if (val1 !== 1'b0) begin
      n_err++; $display("FAIL rr_idle: got v=%b want 0", val1);
    end
    req = 4'b1001;
    step();
    req = 4'd0;
    step();
    n_cmp++; if (val1 !== 1'b1 || out1 !== 2'd0) begin
      n_err++; $display("FAIL rr_reload0: got v=%b o=%b want 1/00", val1, out1);
    end
    step();
    n_cmp++; if (val1 !== 1'b1 || out1 !== 2'd3) begin
      n_err++; $display("FAIL rr_reload1: got v=%b o=%b want 1/11", val1, out1);
    end
    step();
    n_cmp++; if (val1 !== 1'b0 || pend1 !== 4'd0) begin
      n_err++; $display("FAIL rr_drain: got v=%b p=%b want 0/0000", val1, pend1);
    end
    ack = 1'b0;
  endtask

  task automatic test_dup_set_wins();
    do_reset();
    enable = 1'b1; req = 4'b1000;
    step();
    req = 4'd0;
    step();
    req = 4'b0010;
    step();
    n_cmp++; if (dup0 !== 1'b0 || pend0 !== 4'b0010 || out0 !== 2'd3) begin
      n_err++; $display("FAIL dup_first: got d=%b p=%b o=%b want 0/0010/11", dup0, pend0, out0);
    end
    step();
    req = 4'd0;
    n_cmp++; if (dup0 !== 1'b1) begin
      n_err++; $display("FAIL dup_pulse: got d=%b want 1", dup0);
    end
    step();
    n_cmp++; if (dup0 !== 1'b0 || pend0 !== 4'b0010) begin
      n_err++; $display("FAIL dup_end: got d=%b p=%b want 0/0010", dup0, pend0);
    end
    req = 4'b0010; ack = 1'b1;
    step();
    req = 4'd0;
    n_cmp++; if (val0 !== 1'b1 || out0 !== 2'd1 || pend0 !== 4'b0010 || dup0 !== 1'b0) begin
      n_err++; $display("FAIL setwins_edge: got v=%b o=%b p=%b d=%b want 1/01/0010/0", val0, out0, pend0, dup0);
    end
    step();
    ack = 1'b0;
    n_cmp++; if (val0 !== 1'b0 || pend0 !== 4'b0010) begin
      n_err++; $display("FAIL setwins_idle: got v=%b p=%b want 0/0010", val0, pend0);
    end
    step();
    n_cmp++; if (val0 !== 1'b1 || out0 !== 2'd1 || pend0 !== 4'd0) begin
      n_err++; $display("FAIL setwins_regrant: got v=%b o=%b p=%b want 1/01/0000", val0, out0, pend0);
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  task automatic test_enable();
    do_reset();
    enable = 1'b0; req = 4'b1000; ack = 1'b1;
    step(); step();
    n_cmp++; if (val0 !== 1'b0 || pend0 !== 4'd0) begin
      n_err++; $display("FAIL enable_gate: got v=%b p=%b want 0/0000", val0, pend0);
    end
    enable = 1'b1; req = 4'b0101; ack = 1'b0;
    step();
    enable = 1'b0; req = 4'b1000;
    step();
    n_cmp++; if (val0 !== 1'b1 || out0 !== 2'd2 || pend0 !== 4'b0001) begin
      n_err++; $display("FAIL enable_first: got v=%b o=%b p=%b want 1/10/0001", val0, out0, pend0);
    end
    ack = 1'b1;
    step();
    n_cmp++; if (val0 !== 1'b1 || out0 !== 2'd0 || pend0 !== 4'd0) begin
      n_err++; $display("FAIL enable_drain: got v=%b o=%b p=%b want 1/00/0000", val0, out0, pend0);
    end
    step();
    n_cmp++; if (val0 !== 1'b0 || pend0 !== 4'd0) begin
      n_err++; $display("FAIL enable_idle: got v=%b p=%b want 0/0000", val0, pend0);
    end
    ack = 1'b0; req = 4'd0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; enable = 1'b0; req = 4'd0; ack = 1'b0;
    test_reset();
    test_single();
    test_multi();
    test_round_robin();
    test_dup_set_wins();
    test_enable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
